// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: one-cold column drive, synchronised row sampling,
// whole-scan ghost rejection and press/release debouncing with a one-cycle strobe.
module keypad_scan_debounce #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  logic [3:0]  row_s1_q, row_s2_q;
  logic [15:0] dwell_q, dwell_d;
  logic [1:0]  col_q, col_d;
  logic        full_q, full_d;
  logic [1:0]  acc_cnt_q, acc_cnt_d;
  logic [3:0]  acc_code_q, acc_code_d;
  state_t      state_q, state_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  dbc_q, dbc_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        key_held_q, key_held_d;

  logic        sample, scan_end, hit, accept;
  logic [2:0]  col_lows, total;
  logic [1:0]  row_idx;
  logic [3:0]  scan_code;

  function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_lut = 4'h1;  4'h1: key_lut = 4'h2;  4'h2: key_lut = 4'h3;  4'h3: key_lut = 4'hA;
      4'h4: key_lut = 4'h4;  4'h5: key_lut = 4'h5;  4'h6: key_lut = 4'h6;  4'h7: key_lut = 4'hB;
      4'h8: key_lut = 4'h7;  4'h9: key_lut = 4'h8;  4'hA: key_lut = 4'h9;  4'hB: key_lut = 4'hC;
      4'hC: key_lut = 4'hE;  4'hD: key_lut = 4'h0;  4'hE: key_lut = 4'hF;  default: key_lut = 4'hD;
    endcase
  endfunction

  // Per-scan accumulation: low-bit count saturates at 2 since anything above one is no-key.
  always_comb begin
    sample   = ena && (dwell_q == 16'(SCAN_DIV - 1));
    scan_end = sample && (col_q == 2'd3);
    col_lows = {2'b00, ~row_s2_q[0]} + {2'b00, ~row_s2_q[1]}
             + {2'b00, ~row_s2_q[2]} + {2'b00, ~row_s2_q[3]};
    row_idx = 2'd0;
    if (!row_s2_q[0])      row_idx = 2'd0;
    else if (!row_s2_q[1]) row_idx = 2'd1;
    else if (!row_s2_q[2]) row_idx = 2'd2;
    else if (!row_s2_q[3]) row_idx = 2'd3;
    total     = ((col_q == 2'd0) ? 3'd0 : {1'b0, acc_cnt_q}) + col_lows;
    scan_code = (col_lows == 3'd1) ? key_lut(row_idx, col_q) : acc_code_q;
    hit       = (total == 3'd1);
  end

  always_comb begin
    dwell_d    = dwell_q;
    col_d      = col_q;
    full_d     = full_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (!ena) begin
      dwell_d = 16'd0;
      full_d  = 1'b0;
    end else if (sample) begin
      dwell_d    = 16'd0;
      col_d      = col_q + 2'd1;
      acc_cnt_d  = (total >= 3'd2) ? 2'd2 : total[1:0];
      acc_code_d = scan_code;
      if (col_q == 2'd0) full_d = 1'b1;
    end else begin
      dwell_d = dwell_q + 16'd1;
    end
  end

  // A scan end only counts when column 0 was sampled since the last enable.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    dbc_d   = dbc_q;
    rcnt_d  = rcnt_q;
    accept  = 1'b0;
    if (!ena) begin
      state_d = ST_IDLE;
      dbc_d   = 4'd0;
      rcnt_d  = 4'd0;
    end else if (scan_end && full_q) begin
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            cand_d = scan_code;
            dbc_d  = 4'd1;
            if (DEBOUNCE_SCANS == 1) accept = 1'b1;
            else state_d = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (hit && (scan_code == cand_q)) begin
            dbc_d = dbc_q + 4'd1;
            if (dbc_q + 4'd1 == 4'(DEBOUNCE_SCANS)) accept = 1'b1;
          end else begin
            state_d = ST_IDLE;
            dbc_d   = 4'd0;
          end
        end
        ST_HELD: begin
          if (!hit) begin
            rcnt_d = rcnt_q + 4'd1;
            if (rcnt_q + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
              state_d = ST_IDLE;
              rcnt_d  = 4'd0;
            end
          end else begin
            rcnt_d = 4'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (accept) begin
        state_d = ST_HELD;
        rcnt_d  = 4'd0;
        dbc_d   = 4'd0;
      end
    end
  end

  always_comb begin
    key_valid_d = accept;
    key_code_d  = accept ? cand_d : key_code_q;
    key_held_d  = (state_d == ST_HELD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      dwell_q     <= 16'd0;
      col_q       <= 2'd0;
      full_q      <= 1'b0;
      acc_cnt_q   <= 2'd0;
      acc_code_q  <= 4'd0;
      state_q     <= ST_IDLE;
      cand_q      <= 4'd0;
      dbc_q       <= 4'd0;
      rcnt_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_s1_q    <= row_in;
      row_s2_q    <= row_s1_q;
      dwell_q     <= dwell_d;
      col_q       <= col_d;
      full_q      <= full_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      dbc_q       <= dbc_d;
      rcnt_q      <= rcnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_out   = ena ? ~(4'b0001 << col_q) : 4'b1111;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: directed scan table, ena/reset sequences and
// random key activity checked against a scan-level reference model.
module tb_keypad_scan_debounce;

  localparam int SD = 4;
  localparam int DS = 3;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  keypad_scan_debounce #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: bit r*4+c of pressed closes key (r,c).
  logic [15:0] pressed;
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one step per scan) ----------------
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  bit         m_held = 1'b0;
  bit         m_valid = 1'b0;
  logic [3:0] m_code = 4'h0;
  logic [3:0] m_run_code = 4'h0;
  int         m_run_len = 0;
  int         m_rel = 0;

  task automatic model_scan(input logic [15:0] mask);
    bit         one;
    logic [3:0] code;
    one  = ($countones(mask) == 1);
    code = 4'h0;
    for (int k = 0; k < 16; k++) if (mask[k]) code = kmap[k];
    m_valid = 1'b0;
    if (m_held) begin
      if (one) m_rel = 0;
      else begin
        m_rel++;
        if (m_rel == DS) begin m_held = 1'b0; m_rel = 0; end
      end
    end else if (m_run_len == 0) begin
      if (one) begin m_run_code = code; m_run_len = 1; end
    end else if (one && code == m_run_code) begin
      m_run_len++;
    end else begin
      m_run_len = 0;
    end
    if (!m_held && m_run_len == DS) begin
      m_valid = 1'b1; m_code = m_run_code; m_held = 1'b1; m_rel = 0; m_run_len = 0;
    end
  endtask

  // ---------------- driver: one aligned scan of 4*SD cycles ----------------
  task automatic do_scan(input logic [15:0] mask, input bit use_tab,
                         input logic tv, input logic [3:0] tc, input logic th);
    logic       prev_h, ev, eh;
    logic [3:0] prev_c, ec, ecol;
    prev_h = m_held;
    prev_c = m_code;
    pressed = mask;
    model_scan(mask);
    ev = use_tab ? tv : m_valid;
    ec = use_tab ? tc : m_code;
    eh = use_tab ? th : m_held;
    if (ev) exp_q.push_back(ec);
    for (int i = 1; i <= 4*SD; i++) begin
      @(posedge clk); #1;
      ecol = 4'b1111;
      ecol[(i/SD)%4] = 1'b0;
      chk("col_out", col_out, ecol);
      chk("key_valid", key_valid, (i == 4*SD) ? ev : 1'b0);
      chk("key_held", key_held, (i == 4*SD) ? eh : prev_h);
      chk("key_code", key_code, (i == 4*SD) ? ec : prev_c);
      if (key_valid) begin
        if (exp_q.size() == 0) chk("unexpected_pulse", 1'b1, 1'b0);
        else chk("pulse_code", key_code, exp_q.pop_front());
      end
    end
  endtask

  typedef struct {
    logic [15:0] mask;
    logic        v;
    logic [3:0]  code;
    logic        held;
  } vec_t;
  vec_t tab[$];

  task automatic add(input logic [15:0] m, input logic v, input logic [3:0] c,
                     input logic h, input int n);
    vec_t e;
    e.mask = m; e.v = v; e.code = c; e.held = h;
    for (int k = 0; k < n; k++) tab.push_back(e);
  endtask

  int         last_key;
  logic [15:0] rmask;

  initial begin
    pressed = 16'h0;
    ena     = 1'b1;
    rst_n   = 1'b1;

    // Clean press (1,2) -> '6', release
    add(16'h0040, 0, 4'h0, 0, 2);  add(16'h0040, 1, 4'h6, 1, 1);
    add(16'h0040, 0, 4'h6, 1, 2);  add(16'h0000, 0, 4'h6, 1, 2);
    add(16'h0000, 0, 4'h6, 0, 1);
    // Bounce on (3,1) -> '0'
    add(16'h2000, 0, 4'h6, 0, 2);  add(16'h0000, 0, 4'h6, 0, 1);
    add(16'h2000, 0, 4'h6, 0, 2);  add(16'h2000, 1, 4'h0, 1, 1);
    add(16'h2000, 0, 4'h0, 1, 1);  add(16'h0000, 0, 4'h0, 1, 2);
    add(16'h0000, 0, 4'h0, 0, 1);
    // Two keys together: rejected
    add(16'h0801, 0, 4'h0, 0, 6);
    // 'A' accepted, slide to 'F' with no gap, release, then 'F'
    add(16'h0008, 0, 4'h0, 0, 2);  add(16'h0008, 1, 4'hA, 1, 1);
    add(16'h4000, 0, 4'hA, 1, 3);  add(16'h0000, 0, 4'hA, 1, 2);
    add(16'h0000, 0, 4'hA, 0, 1);  add(16'h4000, 0, 4'hA, 0, 2);
    add(16'h4000, 1, 4'hF, 1, 1);  add(16'h0000, 0, 4'hF, 1, 2);
    add(16'h0000, 0, 4'hF, 0, 1);

    // Asynchronous reset mid-cycle
    #12 rst_n = 1'b0;
    #1;
    chk("rst_col_out", col_out, 4'b1110);
    chk("rst_key_code", key_code, 4'h0);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_key_held", key_held, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    foreach (tab[k]) do_scan(tab[k].mask, 1'b1, tab[k].v, tab[k].code, tab[k].held);

    // ena drop mid-debounce: partial scan discarded, fresh debounce required
    do_scan(16'h0040, 1'b0, 1'b0, 4'h0, 1'b0);
    do_scan(16'h0040, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (6) @(posedge clk);
    #1 ena = 1'b0;
    #1 chk("ena_col_off", col_out, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("ena_off_col", col_out, 4'b1111);
      chk("ena_off_valid", key_valid, 1'b0);
      chk("ena_off_held", key_held, 1'b0);
    end
    ena = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      chk("resume_valid", key_valid, (i == 60) ? 1'b1 : 1'b0);
      chk("resume_held", key_held, (i == 60) ? 1'b1 : 1'b0);
    end
    chk("resume_code", key_code, 4'h6);
    chk("resume_col", col_out, 4'b1110);
    m_held = 1'b1; m_code = 4'h6; m_run_len = 0; m_rel = 0;

    // Random key activity against the model
    last_key = 5;
    for (int s = 0; s < 120; s++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 35) rmask = 16'h0;
      else if (r < 85) begin
        if ($urandom_range(0, 4) == 0) last_key = $urandom_range(0, 15);
        rmask = 16'h0;
        rmask[last_key] = 1'b1;
      end else begin
        int a, b;
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        rmask = 16'h0;
        rmask[a] = 1'b1;
        rmask[b] = 1'b1;
      end
      do_scan(rmask, 1'b0, 1'b0, 4'h0, 1'b0);
    end

    // Reset while a key is held
    repeat (3) do_scan(16'h0000, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (3) do_scan(16'h0008, 1'b0, 1'b0, 4'h0, 1'b0);
    chk("pre_rst_held", key_held, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("held_rst_held", key_held, 1'b0);
    chk("held_rst_valid", key_valid, 1'b0);
    chk("held_rst_code", key_code, 4'h0);
    chk("held_rst_col", col_out, 4'b1110);
    chk("pending_pulses", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
